msx_slot_initiator: RTL and testbench

Drives MSX cartridge-slot I/O cycles as the bus master, issuing what a Z80 CPU issues to a slot I/O responder such as `msx_slot`. It takes single-beat requests on the internal `bus_*` handshake and produces IORQ/RD/WR strobes, address and data with Z80-like setup, active and hold phases. It honours the slot WAIT line and returns read data. It runs on `clk42m` and serves as the host-side model for slot-level bench work and for host-side test hardware.

---
 rtl/msx_slot_initiator_if.sv | 37 +++
 rtl/msx_slot_initiator.sv | 211 +++++++++++++++++++++
 tb/tb_msx_slot_initiator.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msx_slot_initiator_if.sv
// msx_slot_initiator_if
//
// Purpose: the internal single-beat request/response handshake between a
// requester (host logic or a bench) and the MSX slot I/O initiator.
//
// Signals:
//   bus_address   requester -> initiator  target I/O port
//   bus_write     requester -> initiator  1 = OUT cycle, 0 = IN cycle
//   bus_valid     requester -> initiator  request present
//   bus_wdata     requester -> initiator  write data
//   bus_ready     initiator -> requester  request accepted when valid && ready
//   bus_rdata     initiator -> requester  read data, held until next read completes
//   bus_rdata_en  initiator -> requester  one-clock pulse when a read finishes
//   bus_timeout   initiator -> requester  one-clock pulse when WAIT aborted a cycle
//
// Modports: master = requester side, slave = initiator side.

interface msx_slot_initiator_if;
    logic [7:0] bus_address;
    logic       bus_write;
    logic       bus_valid;
    logic       bus_ready;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_rdata_en;
    logic       bus_timeout;

    modport master (
        output bus_address, bus_write, bus_valid, bus_wdata,
        input  bus_ready, bus_rdata, bus_rdata_en, bus_timeout
    );

    modport slave (
        input  bus_address, bus_write, bus_valid, bus_wdata,
        output bus_ready, bus_rdata, bus_rdata_en, bus_timeout
    );
endinterface

// File: rtl/msx_slot_initiator.sv
// msx_slot_initiator
//
// Purpose: bus master for MSX cartridge-slot I/O cycles. Each accepted request
// becomes one Z80-like IORQ cycle: address/data setup, IORQ+RD or IORQ+WR low
// for a minimum active time (stretched by the slot WAIT line), then a hold
// phase with the strobes released. Read data is returned on the bus side.
//
// Ports:
//   clk             clk42m, single clock
//   reset           synchronous, active-high
//   bus             request handshake (slave modport of msx_slot_initiator_if)
//   p_slot_address  slot A[7:0]
//   p_slot_ioreq_n  IORQ strobe, active low
//   p_slot_rd_n     RD strobe, active low
//   p_slot_wr_n     WR strobe, active low
//   p_slot_data_o   data driven to the slot
//   p_slot_data_oe  1 = drive p_slot_data_o
//   p_slot_data_i   data from the slot
//   p_slot_wait     responder WAIT, active high, asynchronous

module msx_slot_initiator #(
    parameter int SETUP_CYCLES  = 6,
    parameter int ACTIVE_CYCLES = 24,
    parameter int HOLD_CYCLES   = 6,
    parameter int WAIT_LIMIT    = 4095
) (
    input  logic                 clk,
    input  logic                 reset,
    msx_slot_initiator_if.slave  bus,
    output logic [7:0]           p_slot_address,
    output logic                 p_slot_ioreq_n,
    output logic                 p_slot_rd_n,
    output logic                 p_slot_wr_n,
    output logic [7:0]           p_slot_data_o,
    output logic                 p_slot_data_oe,
    input  logic [7:0]           p_slot_data_i,
    input  logic                 p_slot_wait
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    localparam logic [7:0]  SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0]  ACTIVE_LOAD = 8'(ACTIVE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LOAD   = 8'(HOLD_CYCLES - 1);
    localparam logic [11:0] WAIT_LAST   = 12'(WAIT_LIMIT - 1);

    state_t      state, state_nxt;
    logic [7:0]  phase_cnt, phase_nxt;
    logic [11:0] wait_cnt, wait_nxt;
    logic        write_q, write_nxt;
    logic [7:0]  addr_nxt, data_nxt;
    logic        oe_nxt;
    logic        strobe_nxt;
    logic [7:0]  rdata_q, rdata_nxt;
    logic        rdata_en_q, rdata_en_nxt;
    logic        timeout_q, timeout_nxt;
    logic        wait_meta, wait_s;

    // Ready is combinational on state so a new request is taken in the very
    // clock the initiator returns to IDLE; it is masked while reset is high.
    assign bus.bus_ready    = (state == ST_IDLE) && !reset;
    assign bus.bus_rdata    = rdata_q;
    assign bus.bus_rdata_en = rdata_en_q;
    assign bus.bus_timeout  = timeout_q;

    // WAIT comes from the slot asynchronously; two flops bring it into the
    // clk42m domain and only the second flop is ever looked at.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_meta <= 1'b0;
            wait_s    <= 1'b0;
        end else begin
            wait_meta <= p_slot_wait;
            wait_s    <= wait_meta;
        end
    end

    // Next-state and next-output logic. Every slot output is computed here as
    // the value it should take after the coming edge, so the register block
    // below can keep all slot pins and bus results registered.
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase_cnt;
        wait_nxt     = wait_cnt;
        write_nxt    = write_q;
        addr_nxt     = p_slot_address;
        data_nxt     = p_slot_data_o;
        oe_nxt       = p_slot_data_oe;
        strobe_nxt   = 1'b0;
        rdata_nxt    = rdata_q;
        rdata_en_nxt = 1'b0;
        timeout_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.bus_valid) begin
                    state_nxt = ST_SETUP;
                    phase_nxt = SETUP_LOAD;
                    write_nxt = bus.bus_write;
                    addr_nxt  = bus.bus_address;
                    data_nxt  = bus.bus_wdata;
                    oe_nxt    = bus.bus_write;
                end
            end
            ST_SETUP: begin
                if (phase_cnt == 8'd0) begin
                    state_nxt  = ST_ACTIVE;
                    phase_nxt  = ACTIVE_LOAD;
                    strobe_nxt = 1'b1;
                end else begin
                    phase_nxt = phase_cnt - 8'd1;
                end
            end
            ST_ACTIVE: begin
                strobe_nxt = 1'b1;
                if (phase_cnt == 8'd0) begin
                    if (wait_s) begin
                        state_nxt = ST_WAIT;
                        wait_nxt  = 12'd0;
                    end else begin
                        strobe_nxt = 1'b0;
                        state_nxt  = ST_HOLD;
                        phase_nxt  = HOLD_LOAD;
                        if (!write_q) begin
                            rdata_nxt = p_slot_data_i;
                        end
                    end
                end else begin
                    phase_nxt = phase_cnt - 8'd1;
                end
            end
            ST_WAIT: begin
                strobe_nxt = 1'b1;
                if (!wait_s) begin
                    strobe_nxt = 1'b0;
                    state_nxt  = ST_HOLD;
                    phase_nxt  = HOLD_LOAD;
                    if (!write_q) begin
                        rdata_nxt = p_slot_data_i;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    // Responder never released WAIT: give up, report 0xFF
                    // for a read the way an open bus would read.
                    strobe_nxt  = 1'b0;
                    state_nxt   = ST_HOLD;
                    phase_nxt   = HOLD_LOAD;
                    timeout_nxt = 1'b1;
                    if (!write_q) begin
                        rdata_nxt = 8'hFF;
                    end
                end else begin
                    wait_nxt = wait_cnt + 12'd1;
                end
            end
            ST_HOLD: begin
                if (phase_cnt == 8'd0) begin
                    state_nxt    = ST_IDLE;
                    oe_nxt       = 1'b0;
                    rdata_en_nxt = !write_q;
                end else begin
                    phase_nxt = phase_cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and every registered output. RD and WR are both derived
    // from the single strobe flag and the latched direction, so they can
    // never be low together and never low outside ACTIVE/WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            phase_cnt      <= 8'd0;
            wait_cnt       <= 12'd0;
            write_q        <= 1'b0;
            p_slot_address <= 8'd0;
            p_slot_data_o  <= 8'd0;
            p_slot_data_oe <= 1'b0;
            p_slot_ioreq_n <= 1'b1;
            p_slot_rd_n    <= 1'b1;
            p_slot_wr_n    <= 1'b1;
            rdata_q        <= 8'hFF;
            rdata_en_q     <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state          <= state_nxt;
            phase_cnt      <= phase_nxt;
            wait_cnt       <= wait_nxt;
            write_q        <= write_nxt;
            p_slot_address <= addr_nxt;
            p_slot_data_o  <= data_nxt;
            p_slot_data_oe <= oe_nxt;
            p_slot_ioreq_n <= !strobe_nxt;
            p_slot_rd_n    <= !(strobe_nxt && !write_nxt);
            p_slot_wr_n    <= !(strobe_nxt && write_nxt);
            rdata_q        <= rdata_nxt;
            rdata_en_q     <= rdata_en_nxt;
            timeout_q      <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_msx_slot_initiator.sv
// tb_msx_slot_initiator
//
// Purpose: self-checking bench for msx_slot_initiator. Two instances are
// driven: dut_a with default parameters and dut_b with WAIT_LIMIT = 16 so
// the abort path can be reached quickly. Clock numbering follows the accept
// edge: clock p is the period after the p-th edge following acceptance.
//
// Ports: none (top-level bench).

module tb_msx_slot_initiator;

    localparam int S = 6;
    localparam int A = 24;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_i;
    logic [7:0] addr_a, dout_a, addr_b, dout_b;
    logic       ioreq_a, rd_a, wr_a, oe_a, wait_a;
    logic       ioreq_b, rd_b, wr_b, oe_b, wait_b;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_rdata_a, exp_rdata_b;

    msx_slot_initiator_if bus_a();
    msx_slot_initiator_if bus_b();

    msx_slot_initiator dut_a (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus_a),
        .p_slot_address (addr_a),
        .p_slot_ioreq_n (ioreq_a),
        .p_slot_rd_n    (rd_a),
        .p_slot_wr_n    (wr_a),
        .p_slot_data_o  (dout_a),
        .p_slot_data_oe (oe_a),
        .p_slot_data_i  (data_i),
        .p_slot_wait    (wait_a)
    );

    msx_slot_initiator #(.WAIT_LIMIT(16)) dut_b (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus_b),
        .p_slot_address (addr_b),
        .p_slot_ioreq_n (ioreq_b),
        .p_slot_rd_n    (rd_b),
        .p_slot_wr_n    (wr_b),
        .p_slot_data_o  (dout_b),
        .p_slot_data_oe (oe_b),
        .p_slot_data_i  (data_i),
        .p_slot_wait    (wait_b)
    );

    // 42 MHz is approximated by a 10-unit period; only cycle counts matter.
    always #5 clk = ~clk;

    // Hard stop in case a wait loop is ever broken.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=expired expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit sel, input bit valid, input bit wr,
                             input logic [7:0] addr, input logic [7:0] wdata);
        if (sel) begin
            bus_b.bus_valid   = valid;
            bus_b.bus_write   = wr;
            bus_b.bus_address = addr;
            bus_b.bus_wdata   = wdata;
        end else begin
            bus_a.bus_valid   = valid;
            bus_a.bus_write   = wr;
            bus_a.bus_address = addr;
            bus_a.bus_wdata   = wdata;
        end
    endtask

    task automatic sample(input bit sel, output logic ioreq, output logic rd, output logic wr,
                          output logic oe, output logic ready, output logic en, output logic tmo,
                          output logic [7:0] addr, output logic [7:0] dout, output logic [7:0] rdata);
        ioreq = sel ? ioreq_b : ioreq_a;
        rd    = sel ? rd_b : rd_a;
        wr    = sel ? wr_b : wr_a;
        oe    = sel ? oe_b : oe_a;
        ready = sel ? bus_b.bus_ready : bus_a.bus_ready;
        en    = sel ? bus_b.bus_rdata_en : bus_a.bus_rdata_en;
        tmo   = sel ? bus_b.bus_timeout : bus_a.bus_timeout;
        addr  = sel ? addr_b : addr_a;
        dout  = sel ? dout_b : dout_a;
        rdata = sel ? bus_b.bus_rdata : bus_a.bus_rdata;
    endtask

    // One complete I/O cycle. The expected timeline is worked out from the
    // cycle rules: WAIT is visible internally two clocks after it is driven,
    // it only matters if seen on the last active clock, and it is cut off
    // after 'limit' extension clocks.
    task automatic apply_stimulus(input bit sel, input bit wr, input logic [7:0] addr,
                                  input logic [7:0] wdata, input int din_fixed,
                                  input int ws, input int we, input int limit, input string tag);
        logic [7:0] din [0:511];
        int   L, W, lw, exp_ready, done_p, first_low;
        int   ioreq_low, rd_low, wr_low, both_low, oe_cnt, addr_bad, data_bad;
        int   en_cnt, en_p, to_cnt, to_p;
        bit   tmo;
        logic s_ioreq, s_rd, s_wr, s_oe, s_ready, s_en, s_tmo;
        logic [7:0] s_addr, s_dout, s_rdata, last_rdata, exp_rd;

        L = S + A;
        W = 0;
        tmo = 1'b0;
        if (we >= ws && ws + 2 <= L && we + 2 >= L) begin
            if (we + 2 >= L + limit) begin
                tmo = 1'b1;
                W = limit;
            end else begin
                W = we + 3 - L;
            end
        end
        lw = L + W;
        exp_ready = lw + H + 1;

        done_p = -1; first_low = -1; en_p = -1; to_p = -1;
        ioreq_low = 0; rd_low = 0; wr_low = 0; both_low = 0; oe_cnt = 0;
        addr_bad = 0; data_bad = 0; en_cnt = 0; to_cnt = 0;
        last_rdata = 8'h00;

        drive_req(sel, 1'b1, wr, addr, wdata);
        sample(sel, s_ioreq, s_rd, s_wr, s_oe, s_ready, s_en, s_tmo, s_addr, s_dout, s_rdata);
        check_output({tag, "_ready_idle"}, 32'(s_ready), 32'd1);
        step();
        drive_req(sel, 1'b0, wr, addr, wdata);

        for (int p = 1; p < 500; p++) begin
            din[p] = (din_fixed < 0) ? 8'($urandom) : 8'(din_fixed);
            data_i = din[p];
            if (sel) wait_b = (p >= ws && p <= we);
            else     wait_a = (p >= ws && p <= we);
            sample(sel, s_ioreq, s_rd, s_wr, s_oe, s_ready, s_en, s_tmo, s_addr, s_dout, s_rdata);
            if (!s_ioreq) begin
                ioreq_low++;
                if (first_low < 0) first_low = p;
            end
            if (!s_rd) rd_low++;
            if (!s_wr) wr_low++;
            if (!s_rd && !s_wr) both_low++;
            if (s_oe) oe_cnt++;
            if (p <= lw + H) begin
                if (s_addr !== addr) addr_bad++;
                if (wr && s_dout !== wdata) data_bad++;
            end
            if (s_en) begin
                en_cnt++;
                en_p = p;
            end
            if (s_tmo) begin
                to_cnt++;
                to_p = p;
            end
            if (s_ready) begin
                done_p = p;
                last_rdata = s_rdata;
                break;
            end
            step();
        end
        wait_a = 1'b0;
        wait_b = 1'b0;

        if (!wr) begin
            exp_rd = tmo ? 8'hFF : din[lw];
            if (sel) exp_rdata_b = exp_rd;
            else     exp_rdata_a = exp_rd;
        end
        exp_rd = sel ? exp_rdata_b : exp_rdata_a;

        check_output({tag, "_ready_clock"}, 32'(done_p), 32'(exp_ready));
        check_output({tag, "_first_strobe"}, 32'(first_low), 32'(S + 1));
        check_output({tag, "_ioreq_low"}, 32'(ioreq_low), 32'(A + W));
        check_output({tag, "_rd_low"}, 32'(rd_low), wr ? 32'd0 : 32'(A + W));
        check_output({tag, "_wr_low"}, 32'(wr_low), wr ? 32'(A + W) : 32'd0);
        check_output({tag, "_rd_wr_overlap"}, 32'(both_low), 32'd0);
        check_output({tag, "_oe_clocks"}, 32'(oe_cnt), wr ? 32'(lw + H) : 32'd0);
        check_output({tag, "_addr_stable"}, 32'(addr_bad), 32'd0);
        if (wr) check_output({tag, "_wdata_stable"}, 32'(data_bad), 32'd0);
        check_output({tag, "_rdata_en_count"}, 32'(en_cnt), wr ? 32'd0 : 32'd1);
        if (!wr) check_output({tag, "_rdata_en_clock"}, 32'(en_p), 32'(exp_ready));
        check_output({tag, "_rdata"}, 32'(last_rdata), 32'(exp_rd));
        check_output({tag, "_timeout_count"}, 32'(to_cnt), 32'(tmo));
        if (tmo) check_output({tag, "_timeout_clock"}, 32'(to_p), 32'(lw + 1));
    endtask

    // Directed sequence followed by a randomized batch, then back-to-back
    // traffic and a reset in the middle of a cycle.
    initial begin
        logic s_ioreq, s_rd, s_wr, s_oe, s_ready, s_en, s_tmo;
        logic [7:0] s_addr, s_dout, s_rdata;
        int   r1, r2, first_rd, b_wr_low, b_rd_low, b_both, b_ready_hi, b_en, post_en, post_to;
        bit   rwr, rsel;
        int   rws, rwe;

        reset  = 1'b1;
        data_i = 8'h00;
        wait_a = 1'b0;
        wait_b = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) step();

        sample(1'b0, s_ioreq, s_rd, s_wr, s_oe, s_ready, s_en, s_tmo, s_addr, s_dout, s_rdata);
        check_output("rst_ioreq", 32'(s_ioreq), 32'd1);
        check_output("rst_rd", 32'(s_rd), 32'd1);
        check_output("rst_wr", 32'(s_wr), 32'd1);
        check_output("rst_addr", 32'(s_addr), 32'd0);
        check_output("rst_dout", 32'(s_dout), 32'd0);
        check_output("rst_oe", 32'(s_oe), 32'd0);
        check_output("rst_rdata", 32'(s_rdata), 32'hFF);
        check_output("rst_rdata_en", 32'(s_en), 32'd0);
        check_output("rst_timeout", 32'(s_tmo), 32'd0);
        check_output("rst_ready_masked", 32'(s_ready), 32'd0);
        check_output("rst_ready_masked_b", 32'(bus_b.bus_ready), 32'd0);

        reset = 1'b0;
        #1;
        check_output("rst_ready_release", 32'(bus_a.bus_ready), 32'd1);
        exp_rdata_a = 8'hFF;
        exp_rdata_b = 8'hFF;
        step();

        $display("[TB] directed cycles");
        apply_stimulus(1'b0, 1'b1, 8'h98, 8'h5A, 0, 1, 0, 4095, "out98");
        apply_stimulus(1'b0, 1'b0, 8'h99, 8'h00, 8'hC3, 1, 0, 4095, "in99");
        apply_stimulus(1'b0, 1'b0, 8'h9A, 8'h00, -1, 10, 49, 4095, "wait_ext");
        apply_stimulus(1'b0, 1'b0, 8'h9C, 8'h00, -1, 29, 60, 4095, "wait_late");
        apply_stimulus(1'b0, 1'b0, 8'h9D, 8'h00, -1, 28, 28, 4095, "wait_just");
        apply_stimulus(1'b1, 1'b0, 8'h9B, 8'h00, -1, 1, 120, 16, "timeout_rd");
        apply_stimulus(1'b1, 1'b0, 8'h9E, 8'h00, -1, 5, 43, 16, "limit_edge_ok");
        apply_stimulus(1'b1, 1'b0, 8'h9F, 8'h00, -1, 5, 44, 16, "limit_edge_abort");
        apply_stimulus(1'b1, 1'b1, 8'hA0, 8'h77, -1, 3, 90, 16, "timeout_wr");

        $display("[TB] randomized cycles");
        for (int i = 0; i < 10; i++) begin
            rsel = 1'($urandom);
            rwr  = 1'($urandom);
            rws  = int'($urandom_range(1, 40));
            rwe  = rws + int'($urandom_range(0, 40));
            apply_stimulus(rsel, rwr, 8'($urandom), 8'($urandom), -1, rws, rwe,
                           rsel ? 16 : 4095, $sformatf("rand%0d", i));
        end

        $display("[TB] back-to-back write then read");
        r1 = -1; r2 = -1; first_rd = -1;
        b_wr_low = 0; b_rd_low = 0; b_both = 0; b_ready_hi = 0; b_en = 0;
        data_i = 8'h3C;
        drive_req(1'b0, 1'b1, 1'b1, 8'h10, 8'hA5);
        step();
        for (int p = 1; p < 200; p++) begin
            sample(1'b0, s_ioreq, s_rd, s_wr, s_oe, s_ready, s_en, s_tmo, s_addr, s_dout, s_rdata);
            if (!s_wr) b_wr_low++;
            if (!s_rd) begin
                b_rd_low++;
                if (first_rd < 0) first_rd = p;
            end
            if (!s_rd && !s_wr) b_both++;
            if (s_ready) b_ready_hi++;
            if (s_en) b_en++;
            if (s_ready && r1 < 0) begin
                r1 = p;
                drive_req(1'b0, 1'b1, 1'b0, 8'h11, 8'h00);
            end else if (s_ready) begin
                r2 = p;
                drive_req(1'b0, 1'b0, 1'b0, 8'h11, 8'h00);
                break;
            end
            step();
        end
        exp_rdata_a = 8'h3C;
        check_output("b2b_first_ready", 32'(r1), 32'(S + A + H + 1));
        check_output("b2b_second_ready", 32'(r2), 32'(2 * (S + A + H + 1)));
        check_output("b2b_first_rd_low", 32'(first_rd), 32'(S + A + H + 1 + S + 1));
        check_output("b2b_wr_low", 32'(b_wr_low), 32'(A));
        check_output("b2b_rd_low", 32'(b_rd_low), 32'(A));
        check_output("b2b_overlap", 32'(b_both), 32'd0);
        check_output("b2b_ready_clocks", 32'(b_ready_hi), 32'd2);
        check_output("b2b_rdata_en", 32'(b_en), 32'd1);
        check_output("b2b_rdata", 32'(bus_a.bus_rdata), 32'(exp_rdata_a));
        step();

        $display("[TB] reset in the middle of a read");
        drive_req(1'b0, 1'b1, 1'b0, 8'h22, 8'h00);
        step();
        drive_req(1'b0, 1'b0, 1'b0, 8'h22, 8'h00);
        repeat (14) step();
        check_output("midrst_rd_low_before", 32'(rd_a), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        exp_rdata_a = 8'hFF;
        exp_rdata_b = 8'hFF;
        check_output("midrst_ioreq", 32'(ioreq_a), 32'd1);
        check_output("midrst_rd", 32'(rd_a), 32'd1);
        check_output("midrst_oe", 32'(oe_a), 32'd0);
        check_output("midrst_ready", 32'(bus_a.bus_ready), 32'd1);
        check_output("midrst_rdata", 32'(bus_a.bus_rdata), 32'(exp_rdata_a));
        post_en = 0;
        post_to = 0;
        for (int p = 0; p < 50; p++) begin
            if (bus_a.bus_rdata_en) post_en++;
            if (bus_a.bus_timeout) post_to++;
            if (!ioreq_a) post_to++;
            step();
        end
        check_output("midrst_no_rdata_en", 32'(post_en), 32'd0);
        check_output("midrst_quiet", 32'(post_to), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
